// File: rtl/dmem_stage_if.sv
// Data-memory bus between the MEM-stage front end and a single-ported word memory.
// master drives req/we/addr/wdata; slave returns ready/rdata.
interface dmem_stage_if #(
  parameter int AW = 30
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dmem_stage.sv
// MEM-stage data-memory front end: in-order store buffer with load forwarding,
// load-miss fetch FSM, and stall generation.
// Ports: clk, reset (sync, active-low), memread_mem/memwrite_mem/aluout_mem/
// writedata_mem from EX/MEM, readdata_mem/stall_mem/sb_empty out, mem bus (master).
module dmem_stage #(
  parameter int SB_DEPTH = 4,
  parameter int AW       = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread_mem,
  input  logic        memwrite_mem,
  input  logic [31:0] aluout_mem,
  input  logic [31:0] writedata_mem,
  output logic [31:0] readdata_mem,
  output logic        stall_mem,
  output logic        sb_empty,
  dmem_stage_if.master mem
);

  localparam int PW = $clog2(SB_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_LDONE
  } state_e;

  logic [AW-1:0] sb_addr_q [SB_DEPTH];
  logic [31:0]   sb_data_q [SB_DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW:0]   count_q;
  logic [PW:0]   count_d;
  state_e        state_q;
  logic [AW-1:0] rd_addr_q;
  logic [31:0]   ld_data_q;

  logic [AW-1:0] waddr;
  logic          is_st;
  logic          is_ld;
  logic          full;
  logic          push;
  logic          pop;
  logic          hit;
  logic [31:0]   hit_data;
  logic [PW-1:0] idx;
  logic          miss;
  logic          unused_lo;

  assign waddr     = aluout_mem[AW+1:2];
  assign unused_lo = &{1'b0, aluout_mem[1:0]};

  // Simultaneous read+write is a store.
  assign is_st = memwrite_mem;
  assign is_ld = memread_mem & ~memwrite_mem;

  // Registered count only: a drain this cycle does not free a slot yet.
  assign full = (count_q == (PW+1)'(SB_DEPTH));
  assign push = is_st & ~full;
  assign pop  = (state_q == S_WR) & mem.mem_ready;

  // Scan oldest to youngest so the youngest match wins. The head entry
  // stays valid while its write is in flight.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (((PW+1)'(k) < count_q) && (sb_addr_q[idx] == waddr)) begin
        hit      = 1'b1;
        hit_data = sb_data_q[idx];
      end
    end
  end

  assign miss = is_ld & ~hit & (state_q != S_LDONE);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Entry storage needs no reset: count gates validity.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      sb_addr_q[tail_q] <= waddr;
      sb_data_q[tail_q] <= writedata_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      ld_data_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_d;
      unique case (state_q)
        S_IDLE: begin
          // Loads beat drain; a store pushed into an empty buffer
          // starts draining on the very next cycle.
          if (miss) begin
            state_q   <= S_RD;
            rd_addr_q <= waddr;
          end else if ((count_q != '0) || push) begin
            state_q <= S_WR;
          end
        end
        S_WR: begin
          if (mem.mem_ready) state_q <= S_IDLE;
        end
        S_RD: begin
          if (mem.mem_ready) begin
            ld_data_q <= mem.mem_rdata;
            state_q   <= S_LDONE;
          end
        end
        S_LDONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bus fields come from registers only, so they hold until ready.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (reset) begin
      unique case (state_q)
        S_WR: begin
          mem.mem_req   = 1'b1;
          mem.mem_we    = 1'b1;
          mem.mem_addr  = sb_addr_q[head_q];
          mem.mem_wdata = sb_data_q[head_q];
        end
        S_RD: begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = rd_addr_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata_mem = '0;
    if (reset) begin
      if (state_q == S_LDONE) readdata_mem = ld_data_q;
      else if (is_ld && hit)  readdata_mem = hit_data;
    end
  end

  assign stall_mem = reset & (miss | (is_st & full));
  assign sb_empty  = ~reset | ((count_q == '0) & (state_q != S_WR));

endmodule

// File: doc/dmem_stage.md
Name: dmem_stage

Overview:
- MEM-stage data-memory front end of the 5-stage MIPS pipeline.
- Consumes the EX/MEM register outputs (memwrite_mem, aluout_mem, writedata_mem, load strobe) and returns readdata_mem to the MEM/WB register.
- Holds stores in a small in-order store buffer that drains to an external single-ported word memory over a req/ready handshake.
- Serves loads from the buffer when it holds the address. Otherwise it fetches from memory and asserts stall_mem until the data is available.

Parameters:
SB_DEPTH, 4, store-buffer entries (power of two, >=2)
AW, 30, word-address width (byte address bits [31:2])

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (reset==0 at posedge clears state)
memread_mem  in  1  load in MEM stage (memtoreg_mem)
memwrite_mem  in  1  store in MEM stage
aluout_mem  in  32  byte address; [1:0] ignored
writedata_mem  in  32  store data
readdata_mem  out  32  load data to MEM/WB register
stall_mem  out  1  freeze IF..MEM and bubble WB while 1
sb_empty  out  1  store buffer empty and no store in flight
mem_req  out  1  external memory request
mem_we  out  1  1=write, 0=read
mem_addr  out  AW  word address
mem_wdata  out  32  write data
mem_ready  in  1  transfer completes in cycle sampled high
mem_rdata  in  32  read data, valid when mem_ready=1 and mem_we=0

Behaviour:
- Access granularity:
  - Full-word only. Word address is aluout_mem[31:2].
  - If memread_mem and memwrite_mem are both 1, the access is treated as a store.
- Store buffer:
  - Circular FIFO with head/tail pointers and a count of 0..SB_DEPTH. Each entry holds {addr, data}.
  - full is decoded from the registered count only. A drain completing in the same cycle does not clear full for that cycle.
- Store accept:
  - memwrite_mem=1 and not full: push at the posedge; stall_mem=0.
  - memwrite_mem=1 and full: stall_mem=1. The push happens in the first cycle count<SB_DEPTH.
- Load hit:
  - memread_mem=1 and any valid entry matches the address: readdata_mem = data of the youngest matching entry, combinationally; stall_mem=0.
  - An entry that is currently in flight to memory still counts for matching.
- Load miss requires external read. FSM states:
  - IDLE:
    - If a load miss is present, go to RD with mem_req=1, mem_we=0, mem_addr=load address. Loads have priority over drain.
    - Else if count>0, go to WR with the head entry.
    - Else stay in IDLE.
  - WR:
    - mem_req=1, mem_we=1, addr/wdata = head entry.
    - On mem_ready: pop head and go to IDLE.
    - A load miss arriving during WR stalls until the FSM returns to IDLE.
  - RD:
    - mem_req=1, mem_we=0.
    - On mem_ready: capture mem_rdata into ld_data and go to LDONE.
  - LDONE:
    - readdata_mem=ld_data, stall_mem=0. Go to IDLE next cycle.
- Miss stall:
  - stall_mem=1 from the cycle the miss is first seen through the RD state.
  - Minimum miss latency is 3 cycles (IDLE, RD with ready, LDONE).
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are driven from registered state and stay stable until mem_ready=1.
  - mem_req is deasserted for at least one cycle (IDLE) between transfers.
- readdata_mem is 0 when there is neither a hit nor LDONE.
- sb_empty = (count==0) and the FSM is not in WR.
- Reset:
  - Pointers and count cleared, FSM to IDLE, ld_data=0.
  - While reset==0, outputs are forced: stall_mem=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, readdata_mem=0, sb_empty=1.
  - Reset mid-transfer abandons the request; mem_ready in the following cycles is ignored unless the FSM is in WR or RD.
- Pointer wrap:
  - Modulo SB_DEPTH.
  - A push and a pop in the same cycle leave count unchanged.

Test Plan:
- Reset, then store 0x100 <- 0xDEADBEEF, with mem_ready tied to 1:
  - stall_mem stays 0.
  - Next cycle mem_req=1, mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF.
  - One cycle after that, sb_empty=1.
- Hold mem_ready=0 and issue 5 back-to-back stores to 0x0, 0x4, 0x8, 0xC, 0x10:
  - The first 4 accept without stall.
  - The 5th sees stall_mem=1 until mem_ready pulses.
  - Memory then receives writes in order 0x0, 0x4, 0x8, 0xC, 0x10.
- Store 0x20 <- 1, then store 0x20 <- 2, then load 0x20 with mem_ready=0:
  - readdata_mem=2 in the same cycle, stall_mem=0 (youngest hit, including across wrap).
- Load miss at 0x200 with mem_ready asserted 2 cycles after mem_req and mem_rdata=0x12345678:
  - mem_addr=0x80, mem_we=0.
  - stall_mem=1 for 4 cycles.
  - LDONE cycle shows readdata_mem=0x12345678 with stall_mem=0.
- Load miss while a WR is in flight (mem_ready delayed 3 cycles):
  - The write completes first, then IDLE, then RD.
  - stall_mem stays 1 throughout.
- Pull reset low during RD with a buffer count of 2:
  - Next cycle mem_req=0 and sb_empty=1.
  - A later mem_ready=1 causes no pop and no state change.
